hsv2rgb: RTL
============

Name: hsv2rgb

Overview:
- Pipelined HSV-to-RGB converter; the inverse of the skin-colour segmentation front-end's RGB-to-HSV stage.
- Converts 8-bit H/S/V pixels (H scaled 0..255 for a full circle) back to 8-bit RGB for overlay and debug display of segmentation results.
- Carries hsync/vsync/de alongside the pixel with matched latency.
- Sits between the segmentation/marking logic and the video output path.

Parameters:
- LATENCY, 4, pipeline depth in ce-qualified cycles; fixed, and only 4 is supported (documentation/check value).

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- ce  in  1  clock enable; all pipeline registers advance only when ce=1
- H  in  8  hue, 0..255 = 0..360 deg
- S  in  8  saturation, 0..255
- V  in  8  value, 0..255
- in_hsync  in  1  hsync aligned with H/S/V
- in_vsync  in  1  vsync aligned with H/S/V
- in_de  in  1  data enable aligned with H/S/V
- R  out  8  red
- G  out  8  green
- B  out  8  blue
- out_hsync  out  1  in_hsync delayed by LATENCY
- out_vsync  out  1  in_vsync delayed by LATENCY
- out_de  out  1  in_de delayed by LATENCY

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all pipeline registers, including the sync delay line, clear to 0. R=G=B=0 and out_hsync=out_vsync=out_de=0 on the cycle after rst is sampled high. rst has priority over ce.
- ce=0: every register holds, so outputs are frozen. Latency is counted in ce=1 cycles only. The pipeline never drops or duplicates a pixel.
- Helper mul255(a,b) = round(a*b/255), exact for 8-bit operands:
  - t = a*b + 128 (17 bit)
  - result = (t + (t>>8)) >> 8, 8-bit
- Stage 1:
  - h6 = H*6 (11 bit)
  - sector = h6[10:8], range 0..5
  - f = h6[7:0]
  - register S, V and the sync signals.
- Stage 2: sf = mul255(S,f); sfi = mul255(S,255-f).
- Stage 3:
  - p = mul255(V,255-S)
  - q = mul255(V,255-sf)
  - t = mul255(V,255-sfi)
  - pass V and sector through.
- Stage 4: output register, (R,G,B) selected by sector:
  - 0: (V,t,p)
  - 1: (q,V,p)
  - 2: (p,V,t)
  - 3: (p,q,V)
  - 4: (t,p,V)
  - 5: (V,p,q)
  - 6 and 7 are unreachable and decode as sector 0.
- Total latency: 4 ce-cycles from input sample to R/G/B/out_* update. Sync bits use a 4-deep shift register gated by the same ce.
- S=0: p=q=t=V, so R=G=B=V for any H.
- V=0: R=G=B=0.
- H=255: sector 5, f=250 (near red wrap). There is no H=256, so wrap-around is implicit.
- Fully pipelined: one pixel accepted every ce=1 cycle, no backpressure.
- Reset mid-stream: in-flight pixels are discarded, not flushed.

Optional Feature:
- Macro: HSV2RGB_DE_BLANK_EN.
- Defined: the stage-4 register loads R=G=B=0 whenever the delayed de entering stage 4 is 0, so blanking intervals output black.
- Undefined: R/G/B are computed from H/S/V regardless of de.
- Sync outputs and latency are identical in both builds.

Test Plan:
- rst=1 for 2 cycles with random inputs, ce=1 -> all outputs 0. After release with inputs held at 0, outputs stay 0.
- H=0, S=255, V=255, in_de=1, ce=1 -> 4 cycles later R=255, G=0, B=0, out_de=1.
- H=85, S=255, V=255 -> R=1, G=255, B=0. H=170, S=255, V=255 -> R=0, G=3, B=255 (sector 3, f=252).
- H=100, S=0, V=128 -> R=G=B=128. Also back-to-back pixels each cycle emerge in order with 4-cycle latency and a matching in_hsync pulse.
- Stream of 8 distinct pixels with ce low for 3 cycles mid-stream -> outputs and out_* frozen during the stall. Each pixel still appears after exactly 4 ce-high cycles, with no loss or duplication.
- HSV2RGB_DE_BLANK_EN defined: H=0, S=255, V=255, in_de=0 -> R=G=B=0, out_de=0. Undefined: R=255, G=0, B=0.

Source files
------------

// File: rtl/hsv2rgb.sv
// Four-stage pipelined HSV-to-RGB converter with matched hsync/vsync/de delay.
// Optional HSV2RGB_DE_BLANK_EN forces black output while the delayed de is low.
module hsv2rgb #(
  parameter int unsigned LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic [7:0] H,
  input  logic [7:0] S,
  input  logic [7:0] V,
  input  logic       in_hsync,
  input  logic       in_vsync,
  input  logic       in_de,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic       out_de
);

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned H6_W   = 11;
  localparam int unsigned MUL_W  = 17;
  localparam int unsigned SYNC_W = 3;

  // round(a*b/255) without a divider; exact for all 8-bit operands
  function automatic logic [PIX_W-1:0] mul255(input logic [PIX_W-1:0] a,
                                              input logic [PIX_W-1:0] b);
    logic [MUL_W-1:0] t;
    logic [MUL_W-1:0] u;
    t = MUL_W'(a) * MUL_W'(b) + MUL_W'(128);
    u = t + (t >> 8);
    return PIX_W'(u >> 8);
  endfunction

  logic [H6_W-1:0]   h6;
  logic [2:0]        s1_sector;
  logic [PIX_W-1:0]  s1_f, s1_s, s1_v;
  logic [2:0]        s2_sector;
  logic [PIX_W-1:0]  s2_sf, s2_sfi, s2_s, s2_v;
  logic [2:0]        s3_sector;
  logic [PIX_W-1:0]  s3_p, s3_q, s3_t, s3_v;
  logic [SYNC_W-1:0] sync_d [LATENCY];
  logic [PIX_W-1:0]  r_c, g_c, b_c;

  assign h6 = H6_W'(H) * H6_W'(6);

  // Output colour selection; sectors 6 and 7 never occur and fall back to sector 0
  always_comb begin
    r_c = s3_v;
    g_c = s3_t;
    b_c = s3_p;
    case (s3_sector)
      3'd1:    begin r_c = s3_q; g_c = s3_v; b_c = s3_p; end
      3'd2:    begin r_c = s3_p; g_c = s3_v; b_c = s3_t; end
      3'd3:    begin r_c = s3_p; g_c = s3_q; b_c = s3_v; end
      3'd4:    begin r_c = s3_t; g_c = s3_p; b_c = s3_v; end
      3'd5:    begin r_c = s3_v; g_c = s3_p; b_c = s3_q; end
      default: begin r_c = s3_v; g_c = s3_t; b_c = s3_p; end
    endcase
`ifdef HSV2RGB_DE_BLANK_EN
    if (!sync_d[LATENCY-2][0]) begin
      r_c = '0;
      g_c = '0;
      b_c = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sector <= '0; s1_f <= '0; s1_s <= '0; s1_v <= '0;
      s2_sector <= '0; s2_sf <= '0; s2_sfi <= '0; s2_s <= '0; s2_v <= '0;
      s3_sector <= '0; s3_p <= '0; s3_q <= '0; s3_t <= '0; s3_v <= '0;
      R <= '0; G <= '0; B <= '0;
      for (int i = 0; i < LATENCY; i++) sync_d[i] <= '0;
    end else if (ce) begin
      s1_sector <= h6[10:8];
      s1_f      <= h6[7:0];
      s1_s      <= S;
      s1_v      <= V;

      s2_sector <= s1_sector;
      s2_sf     <= mul255(s1_s, s1_f);
      s2_sfi    <= mul255(s1_s, PIX_W'(8'd255 - s1_f));
      s2_s      <= s1_s;
      s2_v      <= s1_v;

      s3_sector <= s2_sector;
      s3_p      <= mul255(s2_v, PIX_W'(8'd255 - s2_s));
      s3_q      <= mul255(s2_v, PIX_W'(8'd255 - s2_sf));
      s3_t      <= mul255(s2_v, PIX_W'(8'd255 - s2_sfi));
      s3_v      <= s2_v;

      R <= r_c;
      G <= g_c;
      B <= b_c;

      sync_d[0] <= {in_hsync, in_vsync, in_de};
      for (int i = 1; i < LATENCY; i++) sync_d[i] <= sync_d[i-1];
    end
  end

  assign out_hsync = sync_d[LATENCY-1][2];
  assign out_vsync = sync_d[LATENCY-1][1];
  assign out_de    = sync_d[LATENCY-1][0];

endmodule
